// File: rtl/sample_pipeline_arbiter_if.sv
// Bundle between NUM_REQ sample producers, the arbiter, and the pipeline head.
// The arbiter connects through the slave modport; sources and sink use the master modport.
interface sample_pipeline_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 16
);
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_rec;
    logic [W-1:0]         out_data;
    logic                 out_valid;
    logic                 out_rec;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 burst_done;

    modport slave (
        input  req_data, req_valid, out_rec,
        output req_rec, out_data, out_valid, grant, busy, burst_done
    );

    modport master (
        output req_data, req_valid, out_rec,
        input  req_rec, out_data, out_valid, grant, busy, burst_done
    );
endinterface

// File: rtl/sample_pipeline_arbiter.sv
// Round-robin burst arbiter sharing one pipeline head between NUM_REQ sources.
// Optional idle-grant revocation is enabled by defining SPA_TIMEOUT_EN.
module sample_pipeline_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int DATA_SIZE       = 4,
    parameter int DATA_PER_SAMPLE = 4,
    parameter int BURST_LEN       = 4,
    parameter int TIMEOUT         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    sample_pipeline_arbiter_if.slave    bus
);
    localparam int W     = DATA_SIZE * DATA_PER_SAMPLE;
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gidx_q, gidx_d;
    logic               burst_done_q, burst_done_d;

    logic [PTR_W-1:0]   pick;
    logic               pick_vld;
    logic               g_valid;
    logic               xfer;

`ifdef SPA_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0]    idle_q, idle_d;
`else
    logic               unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Search downward so the nearest candidate after ptr is the last one written.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    assign g_valid = bus.req_valid[gidx_q];
    assign xfer    = (state_q == ST_XFER) && g_valid && bus.out_rec;

    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = 1'b0;
        bus.req_rec   = '0;
        if (state_q == ST_XFER) begin
            bus.out_data        = bus.req_data[int'(gidx_q)*W +: W];
            bus.out_valid       = g_valid;
            bus.req_rec[gidx_q] = bus.out_rec & g_valid;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.busy       = (state_q == ST_XFER);
    assign bus.burst_done = burst_done_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        gidx_d       = gidx_q;
        burst_done_d = 1'b0;
`ifdef SPA_TIMEOUT_EN
        idle_d       = idle_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SPA_TIMEOUT_EN
                idle_d = '0;
`endif
                if (pick_vld) begin
                    state_d = ST_XFER;
                    grant_d = NUM_REQ'(1) << pick;
                    gidx_d  = pick;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (xfer) begin
                    if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d      = ST_IDLE;
                        grant_d      = '0;
                        cnt_d        = '0;
                        ptr_d        = gidx_q;
                        burst_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SPA_TIMEOUT_EN
                // Consecutive cycles without valid from the owner; revoke on the TIMEOUT-th.
                if (g_valid) begin
                    idle_d = '0;
                end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
                    idle_d       = '0;
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    cnt_d        = '0;
                    ptr_d        = gidx_q;
                    burst_done_d = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            cnt_q        <= '0;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            gidx_q       <= '0;
            burst_done_q <= 1'b0;
`ifdef SPA_TIMEOUT_EN
            idle_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            gidx_q       <= gidx_d;
            burst_done_q <= burst_done_d;
`ifdef SPA_TIMEOUT_EN
            idle_q       <= idle_d;
`endif
        end
    end
endmodule
